// File: rtl/counter_pkg.sv
// Shared definitions for the counter sequencer: FSM state encodings and the
// one-hot LED patterns that mirror them.
package counter_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StUp   = 2'd1,
        StDown = 2'd2,
        StHold = 2'd3
    } state_e;

    // Led bit order is {HOLD, DOWN, UP, IDLE}
    localparam logic [3:0] LedIdle = 4'b0001;
    localparam logic [3:0] LedUp   = 4'b0010;
    localparam logic [3:0] LedDown = 4'b0100;
    localparam logic [3:0] LedHold = 4'b1000;

    function automatic logic [3:0] state_led(input state_e s);
        logic [3:0] led;
        led = LedIdle;
        unique case (s)
            StIdle: led = LedIdle;
            StUp:   led = LedUp;
            StDown: led = LedDown;
            StHold: led = LedHold;
            default: led = LedIdle;
        endcase
        return led;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioning: 2-flop synchroniser, stable-count debouncer and a
// registered rising-edge press pulse. A level present at reset release is
// learned silently, so a button held through reset gives no press until it
// has been released and pressed again.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int          DB_W            = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam logic [DB_W-1:0] CntLast = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      sync_q;
    logic            level_q, level_d;
    logic            prev_q;
    logic            learn_q, learn_d;
    logic [DB_W-1:0] cnt_q, cnt_d;
    logic            press_q;
    logic            sample;

    assign sample = sync_q[1];

    // Debounce next state. While learning, the level tracks the sample and the
    // counter only has to see it stable; afterwards the counter measures how
    // long the sample has differed from the accepted level.
    always_comb begin
        level_d = level_q;
        learn_d = learn_q;
        cnt_d   = cnt_q;
        if (learn_q) begin
            if (sample != level_q) begin
                level_d = sample;
                cnt_d   = '0;
            end else if (cnt_q == CntLast) begin
                learn_d = 1'b0;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            if (sample == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == CntLast) begin
                level_d = sample;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchroniser, debounce state and registered press pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 2'b00;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            learn_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn};
            level_q <= level_d;
            prev_q  <= level_q;
            learn_q <= learn_d;
            cnt_q   <= cnt_d;
            press_q <= level_q & ~prev_q & ~learn_q;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/counter_sequencer.sv
// Counter sequencer: debounces four buttons and runs the IDLE/UP/DOWN/HOLD
// control FSM for an external counter datapath.
// Optional feature: define COUNTER_SEQ_SATURATE_EN to stop at the counter
// limits (UP at cnt_max, DOWN at cnt_zero) by dropping into HOLD.
module counter_sequencer
    import counter_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int          DB_W            = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       BTNU,
    input  logic       BTND,
    input  logic       BTNC,
    input  logic       BTNR,
    input  logic       cnt_max,
    input  logic       cnt_zero,
    output logic       cnt_en,
    output logic       cnt_up,
    output logic       cnt_clr,
    output logic [1:0] state,
    output logic [3:0] Led
);

    state_e state_q, state_d;
    logic   dir_q, dir_d;
    logic   clr_q, clr_d;
    logic   up_press, down_press, hold_press, clr_press;
    logic   sat;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_up (
        .clk   (clk),
        .rst   (rst),
        .btn   (BTNU),
        .press (up_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_down (
        .clk   (clk),
        .rst   (rst),
        .btn   (BTND),
        .press (down_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_hold (
        .clk   (clk),
        .rst   (rst),
        .btn   (BTNC),
        .press (hold_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_clr (
        .clk   (clk),
        .rst   (rst),
        .btn   (BTNR),
        .press (clr_press)
    );

`ifdef COUNTER_SEQ_SATURATE_EN
    assign sat = ((state_q == StUp) && cnt_max) || ((state_q == StDown) && cnt_zero);
`else
    // Datapath wraps freely; limit flags are deliberately unused
    logic unused_flags;
    assign unused_flags = cnt_max | cnt_zero;
    assign sat          = 1'b0;
`endif

    // Next state: clr > hold > up > down > saturation, only one acts
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        clr_d   = 1'b0;
        if (clr_press) begin
            state_d = StIdle;
            clr_d   = 1'b1;
        end else if (hold_press) begin
            case (state_q)
                StUp: begin
                    state_d = StHold;
                    dir_d   = 1'b1;
                end
                StDown: begin
                    state_d = StHold;
                    dir_d   = 1'b0;
                end
                StHold:  state_d = dir_q ? StUp : StDown;
                default: state_d = state_q;
            endcase
        end else if (up_press) begin
            state_d = StUp;
        end else if (down_press) begin
            state_d = StDown;
        end else if (sat) begin
            state_d = StHold;
        end
    end

    // State, resume direction and clear pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            dir_q   <= 1'b1;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            clr_q   <= clr_d;
        end
    end

    // Datapath controls decoded straight from the current state
    always_comb begin
        cnt_en = 1'b0;
        cnt_up = dir_q;
        case (state_q)
            StUp: begin
                cnt_en = ~sat;
                cnt_up = 1'b1;
            end
            StDown: begin
                cnt_en = ~sat;
                cnt_up = 1'b0;
            end
            default: begin
                cnt_en = 1'b0;
                cnt_up = dir_q;
            end
        endcase
    end

    assign cnt_clr = clr_q;
    assign state   = state_q;
    assign Led     = state_led(state_q);

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed self-checking bench for counter_sequencer with a short debounce
// window. Saturation expectations follow COUNTER_SEQ_SATURATE_EN.
module tb_counter_sequencer;

    localparam int unsigned N   = 8;
    localparam int unsigned LAT = N + 4;
`ifdef COUNTER_SEQ_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       BTNU, BTND, BTNC, BTNR;
    logic       cnt_max, cnt_zero;
    logic       cnt_en, cnt_up, cnt_clr;
    logic [1:0] state;
    logic [3:0] Led;

    int checks = 0;
    int errors = 0;

    counter_sequencer #(.DEBOUNCE_CYCLES(N), .DB_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .BTNU     (BTNU),
        .BTND     (BTND),
        .BTNC     (BTNC),
        .BTNR     (BTNR),
        .cnt_max  (cnt_max),
        .cnt_zero (cnt_zero),
        .cnt_en   (cnt_en),
        .cnt_up   (cnt_up),
        .cnt_clr  (cnt_clr),
        .state    (state),
        .Led      (Led)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, landing 1 time unit after the last one
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        {BTNU, BTND, BTNC, BTNR} = 4'b0000;
        {cnt_max, cnt_zero} = 2'b00;

        // Reset state
        tick(1);
        rst = 1'b0;
        check("rst_state", 32'(state), 32'd0);
        check("rst_led", 32'(Led), 32'b0001);
        check("rst_en", 32'(cnt_en), 32'd0);
        check("rst_up", 32'(cnt_up), 32'd1);
        check("rst_clr", 32'(cnt_clr), 32'd0);
        tick(LAT);

        // Bouncing BTNU: 3 high / 3 low for 30 cycles, then steady high
        for (int p = 0; p < 5; p++) begin
            BTNU = 1'b1;
            tick(3);
            BTNU = 1'b0;
            tick(3);
        end
        check("bounce_idle", 32'(state), 32'd0);
        BTNU = 1'b1;
        tick(LAT - 1);
        check("db_not_early", 32'(state), 32'd0);
        tick(1);
        check("db_up_state", 32'(state), 32'd1);
        check("db_up_led", 32'(Led), 32'b0010);
        check("db_up_en", 32'(cnt_en), 32'd1);
        check("db_up_dir", 32'(cnt_up), 32'd1);
        BTNU = 1'b0;
        tick(LAT);

        // DOWN, hold, resume
        BTND = 1'b1;
        tick(LAT);
        check("down_state", 32'(state), 32'd2);
        check("down_led", 32'(Led), 32'b0100);
        check("down_en", 32'(cnt_en), 32'd1);
        check("down_dir", 32'(cnt_up), 32'd0);
        BTND = 1'b0;
        tick(LAT);
        BTNC = 1'b1;
        tick(LAT);
        check("hold_state", 32'(state), 32'd3);
        check("hold_led", 32'(Led), 32'b1000);
        check("hold_en", 32'(cnt_en), 32'd0);
        check("hold_dir", 32'(cnt_up), 32'd0);
        BTNC = 1'b0;
        tick(LAT);
        BTNC = 1'b1;
        tick(LAT);
        check("resume_state", 32'(state), 32'd2);
        BTNC = 1'b0;
        tick(LAT);

        // Clear and up pressed together while in DOWN
        BTNR = 1'b1;
        BTNU = 1'b1;
        tick(LAT);
        check("simul_state", 32'(state), 32'd0);
        check("simul_clr", 32'(cnt_clr), 32'd1);
        tick(1);
        check("simul_clr_1cyc", 32'(cnt_clr), 32'd0);
        check("simul_no_up", 32'(state), 32'd0);
        BTNR = 1'b0;
        BTNU = 1'b0;
        tick(LAT);
        check("simul_idle", 32'(state), 32'd0);

        // Hold in IDLE is ignored; cnt_up follows the recorded direction
        BTNC = 1'b1;
        tick(LAT);
        check("hold_idle", 32'(state), 32'd0);
        check("idle_dir", 32'(cnt_up), 32'd0);
        BTNC = 1'b0;
        tick(LAT);

        // Up, then up again while in UP
        BTNU = 1'b1;
        tick(LAT);
        check("up_state", 32'(state), 32'd1);
        BTNU = 1'b0;
        tick(LAT);
        BTNU = 1'b1;
        tick(LAT);
        check("up_again", 32'(state), 32'd1);
        BTNU = 1'b0;
        tick(LAT);

        // Saturation at cnt_max while in UP
        cnt_max = 1'b1;
        #1;
        check("sat_en", 32'(cnt_en), SAT ? 32'd0 : 32'd1);
        tick(1);
        check("sat_state", 32'(state), SAT ? 32'd3 : 32'd1);
        check("sat_dir", 32'(cnt_up), SAT ? 32'd0 : 32'd1);
        cnt_max = 1'b0;
        tick(1);
        check("sat_after", 32'(cnt_en), SAT ? 32'd0 : 32'd1);

        // Back to IDLE via clear
        BTNR = 1'b1;
        tick(LAT);
        check("clr_state", 32'(state), 32'd0);
        check("clr_pulse", 32'(cnt_clr), 32'd1);
        BTNR = 1'b0;
        tick(LAT);

        // Reset while in UP with BTNU held
        BTNU = 1'b1;
        tick(LAT);
        check("pre_rst_up", 32'(state), 32'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mid_rst_led", 32'(Led), 32'b0001);
        check("mid_rst_clr", 32'(cnt_clr), 32'd0);
        check("mid_rst_en", 32'(cnt_en), 32'd0);
        tick(3 * LAT);
        check("held_no_press", 32'(state), 32'd0);
        BTNU = 1'b0;
        tick(LAT);
        check("release_idle", 32'(state), 32'd0);
        BTNU = 1'b1;
        tick(LAT - 1);
        check("repress_early", 32'(state), 32'd0);
        tick(1);
        check("repress_up", 32'(state), 32'd1);
        BTNU = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
